// File: rtl/axi_gpio_slave_if.sv
// AXI4 bundle for the PERIP port of axi_gpio_slave. Data is fixed at 64 bits.
// Only the ID width is configurable.
interface axi_gpio_slave_if #(
  parameter int ID_WIDTH = 4
);
  logic [ID_WIDTH-1:0] AWID;
  logic [63:0]         AWADDR;
  logic [7:0]          AWLEN;
  logic [2:0]          AWSIZE;
  logic [1:0]          AWBURST;
  logic                AWVALID;
  logic                AWREADY;
  logic [63:0]         WDATA;
  logic [7:0]          WSTRB;
  logic                WLAST;
  logic                WVALID;
  logic                WREADY;
  logic [ID_WIDTH-1:0] BID;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ID_WIDTH-1:0] ARID;
  logic [63:0]         ARADDR;
  logic [7:0]          ARLEN;
  logic [2:0]          ARSIZE;
  logic [1:0]          ARBURST;
  logic                ARVALID;
  logic                ARREADY;
  logic [ID_WIDTH-1:0] RID;
  logic [63:0]         RDATA;
  logic [1:0]          RRESP;
  logic                RLAST;
  logic                RVALID;
  logic                RREADY;

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  WDATA, WSTRB, WLAST, WVALID, BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    output AWREADY, WREADY, BID, BRESP, BVALID,
    output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output WDATA, WSTRB, WLAST, WVALID, BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    input  AWREADY, WREADY, BID, BRESP, BVALID,
    input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/axi_gpio_slave.sv
// Native 64-bit AXI4 GPIO responder: LED, synchronized switches, scratch and version.
// It has independent read and write FSMs. Each direction allows one outstanding burst.
module axi_gpio_slave #(
  parameter int                   ID_WIDTH   = 4,
  parameter int                   GPIO_WIDTH = 8,
  parameter int                   SW_WIDTH   = 8,
  parameter logic [GPIO_WIDTH-1:0] LED_RESET = '0,
  parameter logic [63:0]          VERSION    = 64'h0000_0001_A21A_0E01
) (
  input  logic                  sys_clk,
  input  logic                  RST,
  axi_gpio_slave_if.slave       PERIP_AXI,
  output logic [GPIO_WIDTH-1:0] led,
  input  logic [SW_WIDTH-1:0]   sw
);
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  // FIXED holds the address; INCR and WRAP both step by the capped beat size.
  function automatic logic [11:0] f_next(input logic [11:0] a, input logic [1:0] burst,
                                         input logic [2:0] size);
    logic [2:0] sz;
    sz = (size > 3'd3) ? 3'd3 : size;
    return (burst == 2'b00) ? a : a + (12'd1 << sz);
  endfunction

  w_state_t r_wst, w_wst_nxt;
  r_state_t r_rst, w_rst_nxt;

  logic [ID_WIDTH-1:0]   r_wid, r_rid;
  logic [11:0]           r_waddr, r_raddr;
  logic [7:0]            r_wlen, r_rlen, r_wcnt, r_rcnt;
  logic [1:0]            r_wburst, r_rburst;
  logic [2:0]            r_wsize, r_rsize;
  logic                  r_werr;
  logic [GPIO_WIDTH-1:0] r_led;
  logic [63:0]           r_scratch;
  logic [SW_WIDTH-1:0]   r_sw_meta, r_sw_sync;
  logic [63:0]           r_rdata;
  logic [1:0]            r_rresp;
  logic                  r_rlast;

  logic        w_awready, w_wready, w_bvalid, w_arready, w_rvalid;
  logic        w_wmapped, w_rerr;
  logic [63:0] w_wmask, w_led_new, w_rdata;
  logic [11:0] w_rnext, w_rsel;

  always_ff @(posedge sys_clk) begin
    if (RST) begin
      r_wst <= W_IDLE;
      r_rst <= R_IDLE;
    end else begin
      r_wst <= w_wst_nxt;
      r_rst <= w_rst_nxt;
    end
  end

  always_comb begin
    w_wst_nxt = r_wst;
    w_awready = 1'b0;
    w_wready  = 1'b0;
    w_bvalid  = 1'b0;
    case (r_wst)
      W_IDLE: begin
        w_awready = !RST;
        if (PERIP_AXI.AWVALID) w_wst_nxt = W_DATA;
      end
      W_DATA: begin
        w_wready = 1'b1;
        if (PERIP_AXI.WVALID && r_wcnt == r_wlen) w_wst_nxt = W_RESP;
      end
      W_RESP: begin
        w_bvalid = 1'b1;
        if (PERIP_AXI.BREADY) w_wst_nxt = W_IDLE;
      end
      default: w_wst_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_rst_nxt = r_rst;
    w_arready = 1'b0;
    w_rvalid  = 1'b0;
    case (r_rst)
      R_IDLE: begin
        w_arready = !RST;
        if (PERIP_AXI.ARVALID) w_rst_nxt = R_DATA;
      end
      R_DATA: begin
        w_rvalid = 1'b1;
        if (PERIP_AXI.RREADY && r_rlast) w_rst_nxt = R_IDLE;
      end
      default: w_rst_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    w_wmask = '0;
    for (int i = 0; i < 8; i++) w_wmask[i*8 +: 8] = {8{PERIP_AXI.WSTRB[i]}};
  end
  assign w_wmapped = (r_waddr[11:5] == 7'd0);
  assign w_led_new = (64'(r_led) & ~w_wmask) | (PERIP_AXI.WDATA & w_wmask);

  always_ff @(posedge sys_clk) begin
    if (RST) begin
      r_wid     <= '0;
      r_waddr   <= '0;
      r_wlen    <= '0;
      r_wburst  <= '0;
      r_wsize   <= '0;
      r_wcnt    <= '0;
      r_werr    <= 1'b0;
      r_led     <= LED_RESET;
      r_scratch <= '0;
    end else begin
      if (w_awready && PERIP_AXI.AWVALID) begin
        r_wid    <= PERIP_AXI.AWID;
        r_waddr  <= PERIP_AXI.AWADDR[11:0];
        r_wlen   <= PERIP_AXI.AWLEN;
        r_wburst <= PERIP_AXI.AWBURST;
        r_wsize  <= PERIP_AXI.AWSIZE;
        r_wcnt   <= '0;
        r_werr   <= 1'b0;
      end
      if (w_wready && PERIP_AXI.WVALID) begin
        r_waddr <= f_next(r_waddr, r_wburst, r_wsize);
        r_wcnt  <= r_wcnt + 8'd1;
        // WLAST must coincide exactly with the final counted beat.
        if (!w_wmapped || (PERIP_AXI.WLAST != (r_wcnt == r_wlen))) r_werr <= 1'b1;
        if (w_wmapped && r_waddr[4:3] == 2'd0) r_led <= w_led_new[GPIO_WIDTH-1:0];
        if (w_wmapped && r_waddr[4:3] == 2'd2)
          r_scratch <= (r_scratch & ~w_wmask) | (PERIP_AXI.WDATA & w_wmask);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (RST) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= sw;
      r_sw_sync <= r_sw_meta;
    end
  end

  // One decode serves both the first beat (from AR) and the following beats.
  assign w_rnext = f_next(r_raddr, r_rburst, r_rsize);
  assign w_rsel  = (r_rst == R_IDLE) ? PERIP_AXI.ARADDR[11:0] : w_rnext;

  always_comb begin
    w_rdata = '0;
    w_rerr  = (w_rsel[11:5] != 7'd0);
    if (!w_rerr) begin
      case (w_rsel[4:3])
        2'd0:    w_rdata = 64'(r_led);
        2'd1:    w_rdata = 64'(r_sw_sync);
        2'd2:    w_rdata = r_scratch;
        default: w_rdata = VERSION;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (RST) begin
      r_rid    <= '0;
      r_raddr  <= '0;
      r_rlen   <= '0;
      r_rburst <= '0;
      r_rsize  <= '0;
      r_rcnt   <= '0;
      r_rdata  <= '0;
      r_rresp  <= '0;
      r_rlast  <= 1'b0;
    end else if (w_arready && PERIP_AXI.ARVALID) begin
      r_rid    <= PERIP_AXI.ARID;
      r_raddr  <= PERIP_AXI.ARADDR[11:0];
      r_rlen   <= PERIP_AXI.ARLEN;
      r_rburst <= PERIP_AXI.ARBURST;
      r_rsize  <= PERIP_AXI.ARSIZE;
      r_rcnt   <= '0;
      r_rdata  <= w_rdata;
      r_rresp  <= w_rerr ? 2'b10 : 2'b00;
      r_rlast  <= (PERIP_AXI.ARLEN == 8'd0);
    end else if (w_rvalid && PERIP_AXI.RREADY && !r_rlast) begin
      r_raddr <= w_rnext;
      r_rcnt  <= r_rcnt + 8'd1;
      r_rdata <= w_rdata;
      r_rresp <= w_rerr ? 2'b10 : 2'b00;
      r_rlast <= (r_rcnt + 8'd1 == r_rlen);
    end
  end

  assign PERIP_AXI.AWREADY = w_awready;
  assign PERIP_AXI.WREADY  = w_wready;
  assign PERIP_AXI.BVALID  = w_bvalid;
  assign PERIP_AXI.BID     = r_wid;
  assign PERIP_AXI.BRESP   = r_werr ? 2'b10 : 2'b00;
  assign PERIP_AXI.ARREADY = w_arready;
  assign PERIP_AXI.RVALID  = w_rvalid;
  assign PERIP_AXI.RID     = r_rid;
  assign PERIP_AXI.RDATA   = r_rdata;
  assign PERIP_AXI.RRESP   = r_rresp;
  assign PERIP_AXI.RLAST   = r_rlast;
  assign led               = r_led;
endmodule

// File: tb/tb_axi_gpio_slave.sv
// Directed bench for axi_gpio_slave. Inputs are driven and outputs sampled on the falling edge.
// Expected values are hand-computed constants.
module tb_axi_gpio_slave;
  localparam logic [63:0] VER = 64'h0000_0001_A21A_0E01;

  logic       sys_clk = 1'b0;
  logic       RST;
  logic [7:0] led, sw;
  int         n_checks = 0, n_errors = 0;

  logic [63:0] wbuf [0:7];
  logic [7:0]  wsb  [0:7];
  logic [63:0] rexp [0:7];
  logic [1:0]  rrexp[0:7];
  logic [3:0]  bid;
  logic [1:0]  bresp;

  axi_gpio_slave_if #(.ID_WIDTH(4)) ifc ();

  axi_gpio_slave #(.ID_WIDTH(4), .GPIO_WIDTH(8), .SW_WIDTH(8)) dut (
    .sys_clk(sys_clk), .RST(RST), .PERIP_AXI(ifc.slave), .led(led), .sw(sw)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] id, input logic [63:0] addr, input int len,
                    input logic [2:0] size, input logic [1:0] burst, input int last_at,
                    output logic [3:0] o_bid, output logic [1:0] o_bresp);
    int t = 0;
    ifc.AWID = id; ifc.AWADDR = addr; ifc.AWLEN = 8'(len);
    ifc.AWSIZE = size; ifc.AWBURST = burst; ifc.AWVALID = 1'b1;
    #1;
    while (!ifc.AWREADY && t < 20) begin @(negedge sys_clk); #1; t++; end
    chk("awready", ifc.AWREADY, 1);
    @(negedge sys_clk);
    ifc.AWVALID = 1'b0;
    for (int b = 0; b <= len; b++) begin
      ifc.WDATA = wbuf[b]; ifc.WSTRB = wsb[b];
      ifc.WLAST = (b == last_at); ifc.WVALID = 1'b1;
      chk("wready", ifc.WREADY, 1);
      @(negedge sys_clk);
    end
    ifc.WVALID = 1'b0; ifc.WLAST = 1'b0;
    chk("bvalid_latency", ifc.BVALID, 1);
    o_bid = ifc.BID; o_bresp = ifc.BRESP;
    ifc.BREADY = 1'b1;
    @(negedge sys_clk);
    ifc.BREADY = 1'b0;
    chk("bvalid_drop", ifc.BVALID, 0);
    chk("aw_reaccept", ifc.AWREADY, 1);
  endtask

  task automatic rd(input logic [3:0] id, input logic [63:0] addr, input int len,
                    input logic [2:0] size, input logic [1:0] burst,
                    input int stall_beat, input string tag);
    int t = 0;
    ifc.ARID = id; ifc.ARADDR = addr; ifc.ARLEN = 8'(len);
    ifc.ARSIZE = size; ifc.ARBURST = burst; ifc.ARVALID = 1'b1;
    #1;
    while (!ifc.ARREADY && t < 20) begin @(negedge sys_clk); #1; t++; end
    chk({tag, "_arready"}, ifc.ARREADY, 1);
    @(negedge sys_clk);
    ifc.ARVALID = 1'b0; ifc.RREADY = 1'b1;
    for (int b = 0; b <= len; b++) begin
      if (b == stall_beat) begin
        ifc.RREADY = 1'b0;
        repeat (3) begin
          chk({tag, "_stall_rdata"}, ifc.RDATA, rexp[b]);
          @(negedge sys_clk);
        end
        ifc.RREADY = 1'b1;
      end
      chk({tag, "_rvalid"}, ifc.RVALID, 1);
      chk({tag, "_rid"},    ifc.RID, id);
      chk({tag, "_rdata"},  ifc.RDATA, rexp[b]);
      chk({tag, "_rresp"},  ifc.RRESP, rrexp[b]);
      chk({tag, "_rlast"},  ifc.RLAST, (b == len));
      @(negedge sys_clk);
    end
    ifc.RREADY = 1'b0;
    chk({tag, "_rvalid_drop"}, ifc.RVALID, 0);
  endtask

  initial begin
    ifc.AWID = '0; ifc.AWADDR = '0; ifc.AWLEN = '0; ifc.AWSIZE = 3'd3; ifc.AWBURST = 2'b01;
    ifc.AWVALID = 1'b0; ifc.WDATA = '0; ifc.WSTRB = '0; ifc.WLAST = 1'b0; ifc.WVALID = 1'b0;
    ifc.BREADY = 1'b0; ifc.ARID = '0; ifc.ARADDR = '0; ifc.ARLEN = '0; ifc.ARSIZE = 3'd3;
    ifc.ARBURST = 2'b01; ifc.ARVALID = 1'b0; ifc.RREADY = 1'b0;
    sw = 8'h00; RST = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("rst_awready", ifc.AWREADY, 0);
    chk("rst_arready", ifc.ARREADY, 0);
    chk("rst_bvalid",  ifc.BVALID, 0);
    chk("rst_rvalid",  ifc.RVALID, 0);
    chk("rst_rdata",   ifc.RDATA, 0);
    chk("rst_led",     led, 0);
    RST = 1'b0; #1;
    chk("post_rst_awready", ifc.AWREADY, 1);
    chk("post_rst_arready", ifc.ARREADY, 1);

    // W before AW must stall.
    @(negedge sys_clk);
    ifc.WVALID = 1'b1; ifc.WDATA = 64'hFF; ifc.WSTRB = 8'hFF; ifc.WLAST = 1'b1;
    @(negedge sys_clk);
    chk("w_before_aw_wready", ifc.WREADY, 0);
    ifc.WVALID = 1'b0; ifc.WLAST = 1'b0;

    wbuf[0] = 64'hA5; wsb[0] = 8'h01;
    wr(4'h3, 64'h000, 0, 3'd3, 2'b01, 0, bid, bresp);
    chk("single_bid", bid, 4'h3);
    chk("single_bresp", bresp, 2'b00);
    chk("single_led", led, 8'hA5);

    sw = 8'h3C;
    repeat (3) @(negedge sys_clk);
    rexp[0] = 64'h3C; rrexp[0] = 2'b00;
    rd(4'h1, 64'h008, 0, 3'd3, 2'b01, -1, "sw_read");

    wbuf[0] = 64'h11; wbuf[1] = 64'h22; wbuf[2] = 64'hDEAD_BEEF_0000_0001; wbuf[3] = 64'h44;
    for (int i = 0; i < 4; i++) wsb[i] = 8'hFF;
    wr(4'h2, 64'h000, 3, 3'd3, 2'b01, 3, bid, bresp);
    chk("incr_bresp", bresp, 2'b00);
    chk("incr_led", led, 8'h11);
    rexp[0] = 64'h11; rexp[1] = 64'h3C; rexp[2] = 64'hDEAD_BEEF_0000_0001; rexp[3] = VER;
    for (int i = 0; i < 4; i++) rrexp[i] = 2'b00;
    rd(4'h4, 64'h000, 3, 3'd3, 2'b01, -1, "incr_readback");

    rexp[0] = 64'hDEAD_BEEF_0000_0001; rexp[1] = VER; rexp[2] = 64'h0;
    rrexp[0] = 2'b00; rrexp[1] = 2'b00; rrexp[2] = 2'b10;
    rd(4'h5, 64'h010, 2, 3'd3, 2'b01, 1, "rburst");

    // FIXED burst with partial strobes on SCRATCH.
    wbuf[0] = 64'h1111_2222_3333_4444; wsb[0] = 8'h0F;
    wbuf[1] = 64'h0000_0000_5555_6666; wsb[1] = 8'h03;
    wr(4'h6, 64'h010, 1, 3'd3, 2'b00, 1, bid, bresp);
    chk("fixed_bresp", bresp, 2'b00);
    rexp[0] = 64'hDEAD_BEEF_3333_6666; rrexp[0] = 2'b00;
    rd(4'h6, 64'h010, 0, 3'd3, 2'b01, -1, "strobe_scratch");

    wbuf[0] = 64'hFFFF; wsb[0] = 8'h03;
    wr(4'h7, 64'h000, 0, 3'd3, 2'b01, 0, bid, bresp);
    rexp[0] = 64'hFF; rrexp[0] = 2'b00;
    rd(4'h7, 64'h004, 0, 3'd3, 2'b01, -1, "led_upper_zero");

    wbuf[0] = 64'h99; wsb[0] = 8'hFF;
    wr(4'h8, 64'h020, 0, 3'd3, 2'b01, 0, bid, bresp);
    chk("unmapped_bresp", bresp, 2'b10);
    chk("unmapped_led", led, 8'hFF);

    wbuf[0] = 64'h5A; wsb[0] = 8'h01;
    wr(4'h9, 64'hFFFF_0000_0000_0000, 0, 3'd3, 2'b01, 0, bid, bresp);
    chk("hi_addr_bresp", bresp, 2'b00);
    chk("hi_addr_led", led, 8'h5A);

    // Early WLAST write concurrent with a read burst.
    wbuf[0] = 64'h99; wsb[0] = 8'hFF; wbuf[1] = 64'h77; wsb[1] = 8'hFF;
    rexp[0] = 64'h3C; rexp[1] = 64'hDEAD_BEEF_3333_6666;
    rrexp[0] = 2'b00; rrexp[1] = 2'b00;
    fork
      wr(4'hA, 64'h000, 1, 3'd3, 2'b01, 0, bid, bresp);
      rd(4'hB, 64'h008, 1, 3'd3, 2'b01, -1, "concurrent");
    join
    chk("early_wlast_bresp", bresp, 2'b10);
    chk("early_wlast_bid", bid, 4'hA);
    chk("early_wlast_led", led, 8'h99);

    // Reset during beat 2 of a LEN=7 burst.
    ifc.AWID = 4'hC; ifc.AWADDR = 64'h000; ifc.AWLEN = 8'd7; ifc.AWSIZE = 3'd3;
    ifc.AWBURST = 2'b00; ifc.AWVALID = 1'b1;
    @(negedge sys_clk);
    ifc.AWVALID = 1'b0;
    ifc.WDATA = 64'h77; ifc.WSTRB = 8'hFF; ifc.WLAST = 1'b0; ifc.WVALID = 1'b1;
    repeat (2) @(negedge sys_clk);
    chk("pre_rst_led", led, 8'h77);
    RST = 1'b1;
    @(negedge sys_clk);
    RST = 1'b0; ifc.WVALID = 1'b0; #1;
    chk("midrst_bvalid", ifc.BVALID, 0);
    chk("midrst_led", led, 8'h00);
    chk("midrst_awready", ifc.AWREADY, 1);
    repeat (3) @(negedge sys_clk);
    chk("midrst_no_b", ifc.BVALID, 0);

    wbuf[0] = 64'h0C; wsb[0] = 8'hFF;
    wr(4'hD, 64'h000, 0, 3'd3, 2'b01, 0, bid, bresp);
    chk("after_rst_bresp", bresp, 2'b00);
    chk("after_rst_bid", bid, 4'hD);
    chk("after_rst_led", led, 8'h0C);
    rexp[0] = 64'h0; rrexp[0] = 2'b00;
    rd(4'hE, 64'h010, 0, 3'd3, 2'b01, -1, "scratch_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
